nios2os_mulx_sequencer: RTL

Iterative 32x32 multiply controller for the Nios II execute path.
- Computes the full 64-bit product from four 16x16 partial products, issued over an external unsigned 16x16 pipelined multiplier port. This is the same dedicated-multiplier primitive style the mul cell uses.
- Returns the low word (MUL) or the signed/unsigned high word (MULXSS/MULXSU/MULXUU) to the writeback stage.
- Sits between operand issue and the hardware multiplier blocks: it feeds them and consumes their products.

---
 rtl/nios2os_mulx_sequencer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/nios2os_mulx_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : nios2os_mulx_sequencer
// Brief    : 32x32 MUL/MULX sequencer over an external pipelined 16x16 multiplier
// Revision : 1.0
// ============================================================================
module nios2os_mulx_sequencer #(
  parameter int MUL_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  output logic        ready,
  output logic        done,
  output logic [31:0] result,
  output logic [15:0] mul_a,
  output logic [15:0] mul_b,
  input  logic [31:0] mul_p
);

  localparam logic [1:0] c_OP_MUL     = 2'b00;
  localparam logic [1:0] c_OP_MULXSU  = 2'b10;
  localparam logic [1:0] c_OP_MULXSS  = 2'b11;
  localparam logic [1:0] c_DRAIN_LAST = 2'(MUL_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_DRAIN = 3'd2,
    S_CORR  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t      r_state;
  logic [1:0]  r_cnt;
  logic [1:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [63:0] r_acc;
  logic        r_ready;
  logic        r_done;
  logic [31:0] r_result;

  // Shift tags ride alongside the multiplier pipeline: code 0/1/2 -> shift 0/16/32
  logic [MUL_LAT-1:0]   r_tag_vld;
  logic [2*MUL_LAT-1:0] r_tag_sh;

  logic        w_accept;
  logic        w_issue;
  logic [1:0]  w_sh;
  logic [1:0]  w_out_sh;
  logic        w_out_vld;
  logic [63:0] w_addend;
  logic [31:0] w_hi_corr;

  assign w_accept  = r_ready & start;
  assign w_issue   = (r_state == S_ISSUE);
  assign w_out_vld = r_tag_vld[MUL_LAT-1];
  assign w_out_sh  = r_tag_sh[2*MUL_LAT-1 -: 2];
  assign w_addend  = {32'd0, mul_p} << {w_out_sh, 4'd0};

  // cnt[0] selects the upper half of A, cnt[1] the upper half of B
  assign mul_a = w_issue ? (r_cnt[0] ? r_a[31:16] : r_a[15:0]) : 16'd0;
  assign mul_b = w_issue ? (r_cnt[1] ? r_b[31:16] : r_b[15:0]) : 16'd0;

  assign ready  = r_ready;
  assign done   = r_done;
  assign result = r_result;

  always_comb begin
    w_sh = 2'd1;
    case (r_cnt)
      2'd0:    w_sh = 2'd0;
      2'd3:    w_sh = 2'd2;
      default: w_sh = 2'd1;
    endcase
  end

  // Two's-complement high-word fixup of the unsigned product
  always_comb begin
    w_hi_corr = r_acc[63:32];
    if ((r_op == c_OP_MULXSU || r_op == c_OP_MULXSS) && r_a[31])
      w_hi_corr = w_hi_corr - r_b;
    if (r_op == c_OP_MULXSS && r_b[31])
      w_hi_corr = w_hi_corr - r_a;
  end

  generate
    if (MUL_LAT == 1) begin : g_tag_single
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_tag_vld <= '0;
          r_tag_sh  <= '0;
        end else begin
          r_tag_vld <= w_issue;
          r_tag_sh  <= w_sh;
        end
      end
    end else begin : g_tag_multi
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_tag_vld <= '0;
          r_tag_sh  <= '0;
        end else begin
          r_tag_vld <= {r_tag_vld[MUL_LAT-2:0], w_issue};
          r_tag_sh  <= {r_tag_sh[2*MUL_LAT-3:0], w_sh};
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= 2'd0;
      r_op     <= 2'd0;
      r_a      <= 32'd0;
      r_b      <= 32'd0;
      r_acc    <= 64'd0;
      r_ready  <= 1'b1;
      r_done   <= 1'b0;
      r_result <= 32'd0;
    end else begin
      r_done <= 1'b0;
      if (w_out_vld)
        r_acc <= r_acc + w_addend;
      case (r_state)
        S_IDLE, S_DONE: begin
          r_ready <= 1'b1;
          if (w_accept) begin
            r_op    <= op;
            r_a     <= src1;
            r_b     <= src2;
            r_acc   <= 64'd0;
            r_cnt   <= 2'd0;
            r_ready <= 1'b0;
            r_state <= S_ISSUE;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_ISSUE: begin
          r_cnt <= r_cnt + 2'd1;
          if (r_cnt == 2'd3) begin
            r_cnt   <= 2'd0;
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (r_cnt == c_DRAIN_LAST) begin
            r_cnt   <= 2'd0;
            r_state <= S_CORR;
          end else begin
            r_cnt <= r_cnt + 2'd1;
          end
        end
        S_CORR: begin
          r_acc[63:32] <= w_hi_corr;
          r_result     <= (r_op == c_OP_MUL) ? r_acc[31:0] : w_hi_corr;
          r_done       <= 1'b1;
          r_ready      <= 1'b1;
          r_state      <= S_DONE;
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
